tdp_bram_be: RTL and testbench
==============================

TDP_BRAM_BE -- requirements
Module: tdp_bram_be

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, address width; depth = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter RDW_MODE, default 0, same-port read-during-write: 0 write-first, 1 read-first.
REQ-004 SHALL have parameter OUT_REG, default 1, extra output pipeline stage: 0 none, 1 one stage.
REQ-005 SHALL have parameter CLR_ON_RESET, default 1, start a clear sweep on reset release: 1 yes, 0 no.
REQ-006 SHALL have the following ports:
  - clk  in  1  single clock; all logic on its rising edge.
  - rst_n  in  1  asynchronous reset, active low.
  - clr_req  in  1  one-cycle request to zero the whole memory.
  - busy  out  1  high while the clear sweep runs.
  - en_a / en_b  in  1  port access enable.
  - we_a / we_b  in  1  write enable; qualified by en_x.
  - be_a / be_b  in  DATA_WIDTH/8  byte enables; bit i covers byte i.
  - addr_a / addr_b  in  ADDR_WIDTH  word address.
  - data_a / data_b  in  DATA_WIDTH  write data.
  - q_a / q_b  out  DATA_WIDTH  read data.
  - q_valid_a / q_valid_b  out  1  q_x carries the result of an access.
  - collision  out  1  one-cycle pulse on a conflicting dual write.

Function
REQ-007 SHALL treat a port access as en_x=1 and busy=0; while busy=1, all port inputs SHALL be ignored.
REQ-008 SHALL on a write access update only the bytes with be_x[i]=1; a write with be_x=0 SHALL leave memory unchanged.
REQ-009 SHALL set read latency to 1+OUT_REG cycles from the access edge to q_x/q_valid_x; q_valid_x SHALL pulse once per access, including write accesses.
REQ-010 SHALL, with RDW_MODE=0, return on a write access the merged word: new bytes where be=1, old bytes where be=0.
REQ-011 SHALL, with RDW_MODE=1, return the pre-write word on a write access.
REQ-012 SHALL hold q_x at its last value when no access completes; q_valid_x SHALL be 0 in those cycles.
REQ-013 SHALL, when one port writes address X and the other port reads X in the same cycle, return the pre-write word to the reading port.
REQ-014 SHALL, when both ports write the same address in the same cycle, take port A's byte for every byte both enable and take each port's own bytes elsewhere.
REQ-015 SHALL, in that case, pulse collision for one cycle on the next clock edge if (be_a & be_b) != 0.
REQ-016 SHALL implement a clear FSM with states IDLE and CLEAR.
  - IDLE -> CLEAR on clr_req=1.
  - In CLEAR, write all-zero words to addresses 0 .. 2**ADDR_WIDTH-1, one per cycle, ascending.
  - CLEAR -> IDLE after the last address is written.
REQ-017 SHALL assert busy from the cycle after clr_req through the last clear write: exactly 2**ADDR_WIDTH cycles.
REQ-018 SHALL ignore clr_req while busy=1; the sweep SHALL NOT restart.
REQ-019 SHALL drive q_valid_x to 0 during CLEAR; accesses already in the OUT_REG pipeline SHALL complete normally.
REQ-020 SHALL infer block RAM for the storage array; the storage array SHALL have no reset.

Reset
REQ-021 SHALL, while rst_n=0, force q_a, q_b, q_valid_a, q_valid_b, collision and the pipeline registers to 0, and clear the sweep address counter to 0.
REQ-022 SHALL, while rst_n=0, hold the FSM in CLEAR with busy=1 if CLR_ON_RESET=1, else in IDLE with busy=0.
REQ-023 SHALL, on rst_n asserted mid-sweep, abort the sweep immediately; with CLR_ON_RESET=1 the sweep SHALL restart from address 0 after release.

Verification (DATA_WIDTH=32, ADDR_WIDTH=4, OUT_REG=1 unless stated)
REQ-024 SHALL cover reset release with CLR_ON_RESET=1 -> busy=1 for exactly 16 cycles, then read of every address returns 0x00000000.
REQ-025 SHALL cover: A writes 0xAABBCCDD to addr 3, be=4'b1111, then writes 0x11223344 to addr 3, be=4'b0101, RDW_MODE=0 -> q_a=0xAA22CC44 two cycles after the second write, with q_valid_a=1 for one cycle.
REQ-026 SHALL cover the same second write with RDW_MODE=1 -> q_a=0xAABBCCDD; a following read returns 0xAA22CC44.
REQ-027 SHALL cover: both ports write addr 5 in one cycle, A=0x000000FF be=4'b0011, B=0xFFFF0000 be=4'b1110 -> collision pulses once; a later read of addr 5 returns 0xFFFF00FF.
REQ-028 SHALL cover: clr_req pulsed, then pulsed again 4 cycles later; port writes issued during busy -> second request ignored, busy=1 for 16 cycles total, writes dropped, all words read 0.
REQ-029 SHALL cover rst_n pulsed low at sweep address 7 -> outputs reset asynchronously, sweep restarts at 0 after release, busy=1 for 16 cycles.

Source files
------------

// File: rtl/tdp_bram_be_if.sv
// ---------------------------------------------------------------------------
// tdp_bram_be_if -- bus bundle for the true dual-port byte-enable RAM.
//
// master modport: the user logic driving the RAM
//   clr_req             : one-cycle request to zero the whole memory
//   en_x / we_x         : access enable / write enable (port A and B)
//   be_x                : byte enables, bit i covers byte i
//   addr_x / data_x     : word address / write data
//   busy                : clear sweep in progress, port inputs ignored
//   q_x / q_valid_x     : read data and its one-cycle valid strobe
//   collision           : pulse on a same-address dual write with overlapping bytes
// slave modport: the RAM itself (directions mirrored)
// ---------------------------------------------------------------------------
interface tdp_bram_be_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  clr_req;
    logic                  busy;
    logic                  en_a;
    logic                  we_a;
    logic [BE_WIDTH-1:0]   be_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] data_a;
    logic [DATA_WIDTH-1:0] q_a;
    logic                  q_valid_a;
    logic                  en_b;
    logic                  we_b;
    logic [BE_WIDTH-1:0]   be_b;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] data_b;
    logic [DATA_WIDTH-1:0] q_b;
    logic                  q_valid_b;
    logic                  collision;

    modport master (
        output clr_req, en_a, we_a, be_a, addr_a, data_a,
        output en_b, we_b, be_b, addr_b, data_b,
        input  busy, q_a, q_valid_a, q_b, q_valid_b, collision
    );

    modport slave (
        input  clr_req, en_a, we_a, be_a, addr_a, data_a,
        input  en_b, we_b, be_b, addr_b, data_b,
        output busy, q_a, q_valid_a, q_b, q_valid_b, collision
    );
endinterface

// File: rtl/tdp_bram_be.sv
// ---------------------------------------------------------------------------
// tdp_bram_be -- true dual-port RAM with byte enables, optional output
// register and a clear sweep that zeroes every word.
//
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous reset, active low
//   bus   : tdp_bram_be_if.slave (clear request/busy, ports A and B, collision)
//
// Storage is split into one byte-wide array per byte lane so that each lane
// is a plain dual-port RAM with a single write enable per port. Port A wins
// any byte both ports write to the same address in the same cycle. A read
// on one port of an address written by the other port in the same cycle
// sees the old word (reads sample the array before the write lands).
// ---------------------------------------------------------------------------
module tdp_bram_be #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int RDW_MODE     = 0,
    parameter int OUT_REG      = 1,
    parameter int CLR_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    tdp_bram_be_if.slave  bus
);
    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic                  w_last;
    logic                  w_busy;
    logic                  w_clr_we;

    logic                  w_acc_a, w_acc_b;
    logic                  w_wr_a, w_wr_b;
    logic                  w_same_addr;
    logic                  r_s1_v_a, r_s1_v_b;
    logic [DATA_WIDTH-1:0] w_s1_q_a, w_s1_q_b;
    logic                  r_collision;

    // ---------------- clear FSM ----------------
    assign w_last = (r_clr_addr == {ADDR_WIDTH{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= (CLR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            r_clr_addr <= '0;
        end else begin
            r_state <= w_state_next;
            // Counter wraps to 0 after the last address, ready for the next sweep.
            if (r_state == ST_CLEAR) begin
                r_clr_addr <= r_clr_addr + ADDR_WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.clr_req) w_state_next = ST_CLEAR;
            ST_CLEAR: if (w_last)      w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy   = 1'b0;
        w_clr_we = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_busy   = 1'b1;
                w_clr_we = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.busy = w_busy;

    // ---------------- access qualification ----------------
    assign w_acc_a     = bus.en_a & ~w_busy;
    assign w_acc_b     = bus.en_b & ~w_busy;
    assign w_wr_a      = w_acc_a & bus.we_a;
    assign w_wr_b      = w_acc_b & bus.we_b;
    assign w_same_addr = (bus.addr_a == bus.addr_b);

    // ---------------- byte lanes ----------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH];
            logic [7:0] r_rd_a, r_rd_b;
            logic       w_own_wr_a, w_own_wr_b;
            logic       w_mem_wr_b;

            assign w_own_wr_a = w_wr_a & bus.be_a[gi];
            assign w_own_wr_b = w_wr_b & bus.be_b[gi];
            // B's byte is dropped only where A writes the same byte of the same word.
            assign w_mem_wr_b = w_own_wr_b & ~(w_own_wr_a & w_same_addr);

            always_ff @(posedge clk) begin
                if (w_clr_we) begin
                    r_mem[r_clr_addr] <= 8'h00;
                end else begin
                    if (w_own_wr_a) r_mem[bus.addr_a] <= bus.data_a[gi*8 +: 8];
                    if (w_mem_wr_b) r_mem[bus.addr_b] <= bus.data_b[gi*8 +: 8];
                end
            end

            // Registered read; holds when no access so q stays stable without OUT_REG.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rd_a <= 8'h00;
                    r_rd_b <= 8'h00;
                end else begin
                    if (w_acc_a) begin
                        r_rd_a <= (RDW_MODE == 0 && w_own_wr_a) ? bus.data_a[gi*8 +: 8]
                                                                : r_mem[bus.addr_a];
                    end
                    if (w_acc_b) begin
                        r_rd_b <= (RDW_MODE == 0 && w_own_wr_b) ? bus.data_b[gi*8 +: 8]
                                                                : r_mem[bus.addr_b];
                    end
                end
            end

            assign w_s1_q_a[gi*8 +: 8] = r_rd_a;
            assign w_s1_q_b[gi*8 +: 8] = r_rd_b;
        end
    endgenerate

    // ---------------- stage-1 valid and collision ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v_a    <= 1'b0;
            r_s1_v_b    <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_s1_v_a    <= w_acc_a;
            r_s1_v_b    <= w_acc_b;
            r_collision <= w_wr_a & w_wr_b & w_same_addr & (|(bus.be_a & bus.be_b));
        end
    end

    assign bus.collision = r_collision;

    // ---------------- optional output stage ----------------
    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] r_q_a, r_q_b;
            logic                  r_qv_a, r_qv_b;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q_a  <= '0;
                    r_q_b  <= '0;
                    r_qv_a <= 1'b0;
                    r_qv_b <= 1'b0;
                end else begin
                    r_qv_a <= r_s1_v_a;
                    r_qv_b <= r_s1_v_b;
                    if (r_s1_v_a) r_q_a <= w_s1_q_a;
                    if (r_s1_v_b) r_q_b <= w_s1_q_b;
                end
            end

            assign bus.q_a       = r_q_a;
            assign bus.q_b       = r_q_b;
            assign bus.q_valid_a = r_qv_a;
            assign bus.q_valid_b = r_qv_b;
        end else begin : g_noreg
            assign bus.q_a       = w_s1_q_a;
            assign bus.q_b       = w_s1_q_b;
            assign bus.q_valid_a = r_s1_v_a;
            assign bus.q_valid_b = r_s1_v_b;
        end
    endgenerate
endmodule

// File: tb/tb_tdp_bram_be.sv
// ---------------------------------------------------------------------------
// tb_tdp_bram_be -- two instances (write-first and read-first) driven with the
// same directed stimulus; expected read words are queued per DUT port when an
// access is issued and popped by a monitor whenever q_valid is seen.
// Scoreboard index: 0 = wf A, 1 = wf B, 2 = rf A, 3 = rf B.
// ---------------------------------------------------------------------------
module tb_tdp_bram_be;
    typedef struct packed {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic clr_req;
    logic en_a, we_a, en_b, we_b;
    logic [3:0]  be_a, be_b;
    logic [3:0]  addr_a, addr_b;
    logic [31:0] data_a, data_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n0, n1;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];
    exp_t sb3[$];

    tdp_bram_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) if0 ();
    tdp_bram_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) if1 ();

    assign if0.clr_req = clr_req;  assign if1.clr_req = clr_req;
    assign if0.en_a    = en_a;     assign if1.en_a    = en_a;
    assign if0.we_a    = we_a;     assign if1.we_a    = we_a;
    assign if0.be_a    = be_a;     assign if1.be_a    = be_a;
    assign if0.addr_a  = addr_a;   assign if1.addr_a  = addr_a;
    assign if0.data_a  = data_a;   assign if1.data_a  = data_a;
    assign if0.en_b    = en_b;     assign if1.en_b    = en_b;
    assign if0.we_b    = we_b;     assign if1.we_b    = we_b;
    assign if0.be_b    = be_b;     assign if1.be_b    = be_b;
    assign if0.addr_b  = addr_b;   assign if1.addr_b  = addr_b;
    assign if0.data_b  = data_b;   assign if1.data_b  = data_b;

    tdp_bram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RDW_MODE(0), .OUT_REG(1), .CLR_ON_RESET(1))
        dut_wf (.clk(clk), .rst_n(rst_n), .bus(if0));
    tdp_bram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RDW_MODE(1), .OUT_REG(1), .CLR_ON_RESET(1))
        dut_rf (.clk(clk), .rst_n(rst_n), .bus(if1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard helpers ----------------
    function automatic int sb_total();
        return sb0.size() + sb1.size() + sb2.size() + sb3.size();
    endfunction

    task automatic push(input int p, input logic [31:0] d);
        exp_t e;
        e.data = d;
        e.cyc  = cyc;
        case (p)
            0: sb0.push_back(e);
            1: sb1.push_back(e);
            2: sb2.push_back(e);
            default: sb3.push_back(e);
        endcase
    endtask

    task automatic check_port(input int p, input logic v, input logic [31:0] d);
        exp_t e;
        int   sz;
        if (v !== 1'b1) return;
        case (p)
            0: sz = sb0.size();
            1: sz = sb1.size();
            2: sz = sb2.size();
            default: sz = sb3.size();
        endcase
        checks++;
        if (sz == 0) begin
            failures++;
            $display("FAIL unexpected_valid port=%0d got=%h required=no_output", p, d);
            return;
        end
        case (p)
            0: e = sb0.pop_front();
            1: e = sb1.pop_front();
            2: e = sb2.pop_front();
            default: e = sb3.pop_front();
        endcase
        if (d !== e.data || (cyc - e.cyc) != 2) begin
            failures++;
            $display("FAIL rd_data port=%0d got=%h latency=%0d required=%h latency=2",
                     p, d, cyc - e.cyc, e.data);
        end
    endtask

    // Monitor: pops an expectation for every valid strobe.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check_port(0, if0.q_valid_a, if0.q_a);
            check_port(1, if0.q_valid_b, if0.q_b);
            check_port(2, if1.q_valid_a, if1.q_a);
            check_port(3, if1.q_valid_b, if1.q_b);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic set_a(input logic we, input logic [3:0] be, input logic [3:0] addr,
                         input logic [31:0] d, input logic [31:0] exp_wf, input logic [31:0] exp_rf);
        en_a = 1'b1; we_a = we; be_a = be; addr_a = addr; data_a = d;
        push(0, exp_wf);
        push(2, exp_rf);
    endtask

    task automatic set_b(input logic we, input logic [3:0] be, input logic [3:0] addr,
                         input logic [31:0] d, input logic [31:0] exp_wf, input logic [31:0] exp_rf);
        en_b = 1'b1; we_b = we; be_b = be; addr_b = addr; data_b = d;
        push(1, exp_wf);
        push(3, exp_rf);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        en_a = 1'b0; we_a = 1'b0;
        en_b = 1'b0; we_b = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb_total() != 0; i++) @(posedge clk);
        #1;
        chk("sb_drain", 32'(sb_total()), 32'd0);
    endtask

    // Counts clock edges at which busy is high (sampled on the preceding negedge).
    task automatic count_busy(output int c0, output int c1);
        bit started;
        started = 1'b0;
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (if0.busy) begin c0++; started = 1'b1; end
            if (if1.busy) c1++;
            if (started && !if0.busy && !if1.busy) break;
        end
    endtask

    task automatic read_all_zero();
        for (int i = 0; i < 16; i++) begin
            set_a(1'b0, 4'h0, 4'(i), 32'h0, 32'h0, 32'h0);
            set_b(1'b0, 4'h0, 4'(15 - i), 32'h0, 32'h0, 32'h0);
            step();
        end
        drain();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0; clr_req = 1'b0;
        en_a = 1'b0; we_a = 1'b0; be_a = 4'h0; addr_a = 4'h0; data_a = 32'h0;
        en_b = 1'b0; we_b = 1'b0; be_b = 4'h0; addr_b = 4'h0; data_b = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_q_a", if0.q_a, 32'h0);
        chk("rst_q_valid_a", {31'b0, if0.q_valid_a}, 32'h0);
        chk("rst_collision", {31'b0, if0.collision}, 32'h0);
        chk("rst_busy_wf", {31'b0, if0.busy}, 32'h1);
        chk("rst_busy_rf", {31'b0, if1.busy}, 32'h1);

        // Sweep after reset release
        @(posedge clk); #2;
        rst_n = 1'b1;
        count_busy(n0, n1);
        chk("init_busy_cycles_wf", 32'(n0), 32'd16);
        chk("init_busy_cycles_rf", 32'(n1), 32'd16);
        @(posedge clk); #1;
        read_all_zero();

        // Byte-enable merge, write-first vs read-first
        set_a(1'b1, 4'b1111, 4'd3, 32'hAABBCCDD, 32'hAABBCCDD, 32'h00000000); step();
        set_a(1'b1, 4'b0101, 4'd3, 32'h11223344, 32'hAA22CC44, 32'hAABBCCDD); step();
        set_a(1'b0, 4'b0000, 4'd3, 32'h0,        32'hAA22CC44, 32'hAA22CC44); step();
        // be=0 write leaves memory unchanged
        set_b(1'b1, 4'b0000, 4'd3, 32'hFFFFFFFF, 32'hAA22CC44, 32'hAA22CC44); step();
        set_b(1'b0, 4'b0000, 4'd3, 32'h0,        32'hAA22CC44, 32'hAA22CC44); step();

        // Cross-port read during write sees the old word
        set_a(1'b1, 4'b1111, 4'd7, 32'h12345678, 32'h12345678, 32'h00000000);
        set_b(1'b0, 4'b0000, 4'd7, 32'h0,        32'h00000000, 32'h00000000); step();
        set_b(1'b0, 4'b0000, 4'd7, 32'h0,        32'h12345678, 32'h12345678); step();

        // Overlapping dual write to addr 5
        set_a(1'b1, 4'b0011, 4'd5, 32'h000000FF, 32'h000000FF, 32'h00000000);
        set_b(1'b1, 4'b1110, 4'd5, 32'hFFFF0000, 32'hFFFF0000, 32'h00000000); step();
        chk("collision_pulse_wf", {31'b0, if0.collision}, 32'h1);
        chk("collision_pulse_rf", {31'b0, if1.collision}, 32'h1);
        set_a(1'b0, 4'b0000, 4'd5, 32'h0, 32'hFFFF00FF, 32'hFFFF00FF); step();
        chk("collision_one_cycle", {31'b0, if0.collision}, 32'h0);

        // Disjoint byte enables on the same address: merge, no collision
        set_a(1'b1, 4'b0001, 4'd6, 32'h000000AA, 32'h000000AA, 32'h00000000);
        set_b(1'b1, 4'b0010, 4'd6, 32'h0000BB00, 32'h0000BB00, 32'h00000000); step();
        chk("no_collision_disjoint", {31'b0, if0.collision}, 32'h0);
        set_b(1'b0, 4'b0000, 4'd6, 32'h0, 32'h0000BBAA, 32'h0000BBAA); step();

        // Port B write, port A read-back
        set_b(1'b1, 4'b1111, 4'd9, 32'hCAFEF00D, 32'hCAFEF00D, 32'h00000000); step();
        set_a(1'b0, 4'b0000, 4'd9, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D); step();
        drain();

        // Output holds with valid low when idle
        repeat (3) step();
        chk("hold_q_a_wf", if0.q_a, 32'hCAFEF00D);
        chk("hold_q_a_rf", if1.q_a, 32'hCAFEF00D);
        chk("hold_q_valid_a", {31'b0, if0.q_valid_a}, 32'h0);

        // Clear request, repeated request and writes while busy
        fork
            count_busy(n0, n1);
            begin
                clr_req = 1'b1; step(); clr_req = 1'b0;
                repeat (3) step();
                clr_req = 1'b1;
                en_a = 1'b1; we_a = 1'b1; be_a = 4'hF; addr_a = 4'd3; data_a = 32'hFFFFFFFF;
                en_b = 1'b1; we_b = 1'b1; be_b = 4'hF; addr_b = 4'd8; data_b = 32'h55555555;
                step(); clr_req = 1'b0;
                en_a = 1'b1; we_a = 1'b1; be_a = 4'hF; addr_a = 4'd15; data_a = 32'h77777777;
                step();
            end
        join
        chk("clr_busy_cycles_wf", 32'(n0), 32'd16);
        chk("clr_busy_cycles_rf", 32'(n1), 32'd16);
        @(posedge clk); #1;
        read_all_zero();

        // Reset in the middle of a sweep
        set_a(1'b1, 4'b1111, 4'd12, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000); step();
        drain();
        clr_req = 1'b1; step(); clr_req = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_q_a", if0.q_a, 32'h0);
        chk("midrst_q_valid_a", {31'b0, if0.q_valid_a}, 32'h0);
        chk("midrst_busy", {31'b0, if0.busy}, 32'h1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        count_busy(n0, n1);
        chk("midrst_busy_cycles_wf", 32'(n0), 32'd16);
        chk("midrst_busy_cycles_rf", 32'(n1), 32'd16);
        @(posedge clk); #1;
        read_all_zero();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
